// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port backing memory between the instruction-fetch port
//   and the load/store port. One request is accepted at a time over
//   valid/ready. The accepted request is driven to the memory for one cycle.
//   Read data is captured after MEM_LAT cycles and returned as a one-cycle
//   response pulse to the port that owns the transaction.
//
//   Build option: MEM_ARB_RR_EN
//     undefined : fixed priority, the data port wins every tie
//     defined   : round-robin tie-break with a 1-bit last-grant pointer
//
// Parameters
//   ADDR_WIDTH  address width, all ports
//   DATA_WIDTH  data width, all ports
//   MEM_LAT     cycles from read strobe to valid pMem_bRdData (1..15)
//
// Ports
//   clock, resetN                         clock / async active-low reset
//   pInst_bReq{Valid,Ready}, pInst_bAddr  fetch request
//   pInst_bResp{Valid,Data}               fetch response pulse
//   pData_bReq{Valid,Ready}, pData_bWen,
//   pData_bAddr, pData_bWrData,
//   pData_bMask                           load/store request
//   pData_bResp{Valid,Data}               load data / store ack pulse
//   pMem_b{En,Wen,Addr,WrData,Mask}       memory request (valid in ISSUE only)
//   pMem_bRdData                          memory read data
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  pInst_bReqValid,
    output logic                  pInst_bReqReady,
    input  logic [ADDR_WIDTH-1:0] pInst_bAddr,
    output logic                  pInst_bRespValid,
    output logic [DATA_WIDTH-1:0] pInst_bRespData,
    input  logic                  pData_bReqValid,
    output logic                  pData_bReqReady,
    input  logic                  pData_bWen,
    input  logic [ADDR_WIDTH-1:0] pData_bAddr,
    input  logic [DATA_WIDTH-1:0] pData_bWrData,
    input  logic [3:0]            pData_bMask,
    output logic                  pData_bRespValid,
    output logic [DATA_WIDTH-1:0] pData_bRespData,
    output logic                  pMem_bEn,
    output logic                  pMem_bWen,
    output logic [ADDR_WIDTH-1:0] pMem_bAddr,
    output logic [DATA_WIDTH-1:0] pMem_bWrData,
    output logic [3:0]            pMem_bMask,
    input  logic [DATA_WIDTH-1:0] pMem_bRdData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner_d;   // 1 = data port owns the transaction
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_mask;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rdcap;

    logic w_idle;
    logic w_grant_d;
    logic w_hs_i;
    logic w_hs_d;
    logic w_cnt_zero;

    // Readies depend on live valids, so they are also gated by resetN to keep
    // every output low while reset is held.
    assign w_idle     = (r_state == S_IDLE) && resetN;
    assign w_cnt_zero = (r_cnt == '0);

`ifdef MEM_ARB_RR_EN
    logic r_last_d;   // last granted port, 1 = data

    // On a tie the port not granted last wins.
    assign w_grant_d = pData_bReqValid && (!pInst_bReqValid || !r_last_d);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_last_d <= 1'b1;
        end else if (w_hs_d) begin
            r_last_d <= 1'b1;
        end else if (w_hs_i) begin
            r_last_d <= 1'b0;
        end
    end
`else
    assign w_grant_d = pData_bReqValid;
`endif

    assign w_hs_d = w_idle && w_grant_d;
    assign w_hs_i = w_idle && pInst_bReqValid && !w_grant_d;

    assign pData_bReqReady = w_hs_d;
    assign pInst_bReqReady = w_hs_i;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        pMem_bEn         = 1'b0;
        pMem_bWen        = 1'b0;
        pMem_bAddr       = '0;
        pMem_bWrData     = '0;
        pMem_bMask       = '0;
        pInst_bRespValid = 1'b0;
        pInst_bRespData  = '0;
        pData_bRespValid = 1'b0;
        pData_bRespData  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_hs_i || w_hs_d) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pMem_bEn     = 1'b1;
                pMem_bWen    = r_wen;
                pMem_bAddr   = r_addr;
                pMem_bWrData = r_wdata;
                pMem_bMask   = r_mask;
                w_state_nxt  = r_wen ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_owner_d) begin
                    pData_bRespValid = 1'b1;
                    pData_bRespData  = r_wen ? '0 : r_rdcap;
                end else begin
                    pInst_bRespValid = 1'b1;
                    pInst_bRespData  = r_rdcap;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fetch requests are latched with write disabled and a full-word mask so
    // the ISSUE state can drive the latched fields without a port mux.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_owner_d <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_rdcap   <= '0;
        end else begin
            if (w_hs_d) begin
                r_owner_d <= 1'b1;
                r_wen     <= pData_bWen;
                r_addr    <= pData_bAddr;
                r_wdata   <= pData_bWrData;
                r_mask    <= pData_bMask;
            end else if (w_hs_i) begin
                r_owner_d <= 1'b0;
                r_wen     <= 1'b0;
                r_addr    <= pInst_bAddr;
                r_wdata   <= '0;
                r_mask    <= '1;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= LAT_M1;
            end else if (r_state == S_WAIT && !w_cnt_zero) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_WAIT && w_cnt_zero) begin
                r_rdcap <= pMem_bRdData;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;

    logic        clock = 1'b0;
    logic        resetN;
    logic        pInst_bReqValid, pInst_bReqReady, pInst_bRespValid;
    logic [31:0] pInst_bAddr, pInst_bRespData;
    logic        pData_bReqValid, pData_bReqReady, pData_bWen, pData_bRespValid;
    logic [31:0] pData_bAddr, pData_bWrData, pData_bRespData;
    logic [3:0]  pData_bMask;
    logic        pMem_bEn, pMem_bWen;
    logic [31:0] pMem_bAddr, pMem_bWrData, pMem_bRdData;
    logic [3:0]  pMem_bMask;

    logic [137:0] all_outs;
    assign all_outs = {pInst_bReqReady, pInst_bRespValid, pInst_bRespData,
                       pData_bReqReady, pData_bRespValid, pData_bRespData,
                       pMem_bEn, pMem_bWen, pMem_bAddr, pMem_bWrData, pMem_bMask};

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LAT(LAT)) dut (
        .clock(clock), .resetN(resetN),
        .pInst_bReqValid(pInst_bReqValid), .pInst_bReqReady(pInst_bReqReady),
        .pInst_bAddr(pInst_bAddr), .pInst_bRespValid(pInst_bRespValid),
        .pInst_bRespData(pInst_bRespData),
        .pData_bReqValid(pData_bReqValid), .pData_bReqReady(pData_bReqReady),
        .pData_bWen(pData_bWen), .pData_bAddr(pData_bAddr),
        .pData_bWrData(pData_bWrData), .pData_bMask(pData_bMask),
        .pData_bRespValid(pData_bRespValid), .pData_bRespData(pData_bRespData),
        .pMem_bEn(pMem_bEn), .pMem_bWen(pMem_bWen), .pMem_bAddr(pMem_bAddr),
        .pMem_bWrData(pMem_bWrData), .pMem_bMask(pMem_bMask),
        .pMem_bRdData(pMem_bRdData)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory environment and reference model ----------------
    function automatic logic [31:0] init_val(input int unsigned i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 0) ? 32'h0000_0013 : {b, ~b, 8'hA5, b ^ 8'h3C};
    endfunction

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] pipe [LAT];
    logic        mem_loaded = 1'b0;
    logic        ref_last_d;   // expected last-granted port (1 = data)

    assign pMem_bRdData = pipe[LAT-1];

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (pMem_bEn && pMem_bWen) begin
            for (int b = 0; b < 4; b++)
                if (pMem_bMask[b]) mem[pMem_bAddr[9:2]][8*b +: 8] <= pMem_bWrData[8*b +: 8];
        end
        for (int s = LAT - 1; s > 0; s--) pipe[s] <= pipe[s-1];
        pipe[0] <= (pMem_bEn && !pMem_bWen) ? mem[pMem_bAddr[9:2]] : $urandom;
    end

    function automatic void ref_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Expected winner of a tie: 1 = data port.
    function automatic logic tie_d();
`ifdef MEM_ARB_RR_EN
        return !ref_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- driver: one request on one port, observations out ----------------
    task automatic run_req(input logic port_d, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           output int hs_wait, output int en_k, output logic m_wen,
                           output logic [31:0] m_addr, output logic [31:0] m_wdata,
                           output logic [3:0] m_mask, output int resp_k,
                           output logic [31:0] rdata, output int stray);
        hs_wait = -1; en_k = -1; resp_k = -1; stray = 0;
        m_wen = 1'b0; m_addr = '0; m_wdata = '0; m_mask = '0; rdata = '0;
        if (port_d) begin
            pData_bReqValid = 1'b1; pData_bWen = wen; pData_bAddr = addr;
            pData_bWrData = wdata; pData_bMask = mask;
        end else begin
            pInst_bReqValid = 1'b1; pInst_bAddr = addr;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (port_d ? pData_bReqReady : pInst_bReqReady) begin
                hs_wait = c;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        pInst_bReqValid = 1'b0; pData_bReqValid = 1'b0;
        pInst_bAddr = $urandom; pData_bAddr = $urandom; pData_bWrData = $urandom;
        pData_bMask = 4'($urandom); pData_bWen = 1'($urandom);
        if (hs_wait < 0) return;
        ref_last_d = port_d;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (pMem_bEn) begin
                if (en_k < 0) begin
                    en_k = k; m_wen = pMem_bWen; m_addr = pMem_bAddr;
                    m_wdata = pMem_bWrData; m_mask = pMem_bMask;
                end else stray++;
            end
            if (port_d ? pInst_bRespValid : pData_bRespValid) stray++;
            if (port_d ? pData_bRespValid : pInst_bRespValid) begin
                resp_k = k;
                rdata = port_d ? pData_bRespData : pInst_bRespData;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    // ---------------- streaming scenario: valids held across handshakes ----------------
    task automatic stream(input logic use_i, input logic use_d, input int n_hs, input int d_max,
                          input logic [31:0] i_addr0, input logic [31:0] d_addr0,
                          input logic d_wen0, input string tag);
        int hs = 0, d_cnt = 0, last_hs = 0, gap_need = 0, resp_at = -1;
        logic resp_d = 1'b0, win_d, done = 1'b0;
        logic [31:0] resp_exp = '0, a;
        logic [1:0] exp_rv;
        pInst_bReqValid = use_i; pInst_bAddr = i_addr0;
        pData_bReqValid = use_d && (d_max > 0); pData_bAddr = d_addr0; pData_bWen = d_wen0;
        pData_bWrData = $urandom; pData_bMask = 4'($urandom);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            exp_rv = (cyc == resp_at) ? (resp_d ? 2'b01 : 2'b10) : 2'b00;
            n_cmp++;
            if ({pInst_bRespValid, pData_bRespValid} !== exp_rv) begin
                n_fail++;
                $display("FAIL %s_resp_valid cyc %0d: got %b expected %b", tag, cyc,
                         {pInst_bRespValid, pData_bRespValid}, exp_rv);
            end
            if (cyc == resp_at) begin
                n_cmp++;
                if ((resp_d ? pData_bRespData : pInst_bRespData) !== resp_exp) begin
                    n_fail++;
                    $display("FAIL %s_resp_data cyc %0d: got %h expected %h", tag, cyc,
                             resp_d ? pData_bRespData : pInst_bRespData, resp_exp);
                end
            end
            if (hs == n_hs && cyc >= resp_at) begin
                done = 1'b1;
                break;
            end
            if (hs < n_hs && (pInst_bReqReady || pData_bReqReady)) begin
                win_d = (pInst_bReqValid && pData_bReqValid) ? tie_d() : pData_bReqValid;
                n_cmp++;
                if ({pInst_bReqReady, pData_bReqReady} !== {!win_d, win_d}) begin
                    n_fail++;
                    $display("FAIL %s_grant hs %0d: got i/d %b expected %b", tag, hs,
                             {pInst_bReqReady, pData_bReqReady}, {!win_d, win_d});
                end
                if (hs > 0) begin
                    n_cmp++;
                    if (cyc - last_hs != gap_need) begin
                        n_fail++;
                        $display("FAIL %s_gap hs %0d: got %0d cycles expected %0d", tag, hs,
                                 cyc - last_hs, gap_need);
                    end
                end
                resp_d = win_d; last_hs = cyc; hs++;
                if (win_d && pData_bWen) begin
                    ref_store(pData_bAddr, pData_bWrData, pData_bMask);
                    resp_exp = '0; resp_at = cyc + 2; gap_need = 3;
                end else begin
                    a = win_d ? pData_bAddr : pInst_bAddr;
                    resp_exp = ref_mem[a[9:2]]; resp_at = cyc + 2 + LAT; gap_need = 3 + LAT;
                end
                ref_last_d = win_d;
                if (win_d) d_cnt++;
                @(posedge clock); #1;
                if (hs == n_hs) begin
                    pInst_bReqValid = 1'b0; pData_bReqValid = 1'b0;
                end else if (win_d) begin
                    pData_bReqValid = (d_cnt < d_max);
                    pData_bWen = 1'($urandom_range(0, 1));
                    pData_bAddr = $urandom & 32'h0000_003C;
                    pData_bWrData = $urandom; pData_bMask = 4'($urandom);
                end else begin
                    pInst_bAddr = pInst_bAddr + 32'd4;
                end
            end else begin
                @(posedge clock); #1;
            end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d handshakes expected %0d", tag, hs, n_hs);
        end
        pInst_bReqValid = 1'b0; pData_bReqValid = 1'b0;
        @(posedge clock); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic wd;
        pInst_bReqValid = 1'b1; pData_bReqValid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        pInst_bReqValid = 1'b0; pData_bReqValid = 1'b0;
        #2 resetN = 1'b1;
        @(posedge clock); #1;
        pInst_bReqValid = 1'b1; pData_bReqValid = 1'b1;
        @(negedge clock);
        wd = tie_d();
        n_cmp++;
        if ({pInst_bReqReady, pData_bReqReady} !== {!wd, wd}) begin
            n_fail++;
            $display("FAIL reset_first_tie: got i/d %b expected %b",
                     {pInst_bReqReady, pData_bReqReady}, {!wd, wd});
        end
        #1 pInst_bReqValid = 1'b0; pData_bReqValid = 1'b0;
        #1;
        n_cmp++;
        if ({pInst_bReqReady, pData_bReqReady} !== 2'b00) begin
            n_fail++;
            $display("FAIL ready_follows_valid: got %b expected 00", {pInst_bReqReady, pData_bReqReady});
        end
        @(posedge clock); #1;
        pInst_bReqValid = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({pInst_bReqReady, pData_bReqReady, pMem_bEn} !== 3'b100) begin
            n_fail++;
            $display("FAIL withdrawn_request: got rdy_i/rdy_d/en %b expected 100",
                     {pInst_bReqReady, pData_bReqReady, pMem_bEn});
        end
        #1 pInst_bReqValid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_fetch();
        int hw, ek, rk, st; logic mw; logic [31:0] ma, md, rd; logic [3:0] mm;
        run_req(1'b0, 1'b0, 32'h8000_0000, '0, 4'hF, hw, ek, mw, ma, md, mm, rk, rd, st);
        n_cmp++;
        if (hw != 0 || ek != 1 || st != 0) begin
            n_fail++;
            $display("FAIL fetch_handshake: got wait %0d en_cyc %0d stray %0d expected 0 1 0", hw, ek, st);
        end
        n_cmp++;
        if ({mw, ma, mm} !== {1'b0, 32'h8000_0000, 4'hF}) begin
            n_fail++;
            $display("FAIL fetch_mem_req: got wen %b addr %h mask %b expected 0 80000000 1111", mw, ma, mm);
        end
        n_cmp++;
        if (rk != 2 + LAT || rd !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL fetch_resp: got cyc %0d data %h expected cyc %0d data 00000013", rk, rd, 2 + LAT);
        end
    endtask

    task automatic test_store();
        int hw, ek, rk, st; logic mw; logic [31:0] ma, md, rd, exp; logic [3:0] mm;
        run_req(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0001, hw, ek, mw, ma, md, mm, rk, rd, st);
        ref_store(32'h0000_0100, 32'hDEAD_BEEF, 4'b0001);
        n_cmp++;
        if (ek != 1 || {mw, ma, md, mm} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0001}) begin
            n_fail++;
            $display("FAIL store_mem_req: got cyc %0d wen %b addr %h data %h mask %b expected 1 1 00000100 deadbeef 0001",
                     ek, mw, ma, md, mm);
        end
        n_cmp++;
        if (rk != 2 || rd !== '0 || st != 0) begin
            n_fail++;
            $display("FAIL store_ack: got cyc %0d data %h stray %0d expected 2 0 0", rk, rd, st);
        end
        exp = ref_mem[64];
        run_req(1'b1, 1'b0, 32'h0000_0100, '0, 4'hF, hw, ek, mw, ma, md, mm, rk, rd, st);
        n_cmp++;
        if (hw != 0 || rk != 2 + LAT || rd !== exp) begin
            n_fail++;
            $display("FAIL store_readback: got wait %0d cyc %0d data %h expected 0 %0d %h", hw, rk, rd, 2 + LAT, exp);
        end
    endtask

    task automatic test_random();
        int hw, ek, rk, st; logic mw; logic [31:0] ma, md, rd, exp, a, wd; logic [3:0] mm, mk;
        logic pd, wen;
        for (int t = 0; t < 24; t++) begin
            pd = 1'($urandom_range(0, 1));
            wen = pd ? 1'($urandom_range(0, 1)) : 1'b0;
            a = $urandom & 32'hFFFF_F03F;
            wd = $urandom;
            case ($urandom_range(0, 3))
                0: mk = 4'b0001;
                1: mk = 4'b0011;
                2: mk = 4'b1111;
                default: mk = 4'($urandom);
            endcase
            exp = wen ? 32'h0 : ref_mem[a[9:2]];
            run_req(pd, wen, a, wd, mk, hw, ek, mw, ma, md, mm, rk, rd, st);
            n_cmp++;
            if (hw != 0 || ek != 1 || st != 0) begin
                n_fail++;
                $display("FAIL rand_handshake t%0d: got wait %0d en_cyc %0d stray %0d expected 0 1 0", t, hw, ek, st);
            end
            n_cmp++;
            if ({mw, ma, mm} !== {wen, a, pd ? mk : 4'hF}) begin
                n_fail++;
                $display("FAIL rand_mem_req t%0d: got %b %h %b expected %b %h %b", t, mw, ma, mm,
                         wen, a, pd ? mk : 4'hF);
            end
            if (wen) begin
                ref_store(a, wd, mk);
                n_cmp++;
                if (md !== wd) begin
                    n_fail++;
                    $display("FAIL rand_wdata t%0d: got %h expected %h", t, md, wd);
                end
            end
            n_cmp++;
            if (rk != (wen ? 2 : 2 + LAT) || rd !== exp) begin
                n_fail++;
                $display("FAIL rand_resp t%0d: got cyc %0d data %h expected cyc %0d data %h", t, rk, rd,
                         wen ? 2 : 2 + LAT, exp);
            end
        end
    endtask

    task automatic test_tie();
        // load 0x200 and fetch 0x0 together; data port then withdraws
        stream(1'b1, 1'b1, 2, 1, 32'h0000_0000, 32'h0000_0200, 1'b0, "tie_once");
        // both ports held valid for four transactions
        stream(1'b1, 1'b1, 4, 4, 32'h0000_0010, 32'h0000_0020, 1'b0, "tie_cont");
    endtask

    task automatic test_back_to_back();
        stream(1'b1, 1'b0, 6, 0, 32'h0000_0000, 32'h0, 1'b0, "fetch_stream");
        stream(1'b0, 1'b1, 8, 8, 32'h0, 32'h0000_0004, 1'b1, "data_stream");
    endtask

    task automatic test_reset_mid();
        int hw, ek, rk, st; logic mw; logic [31:0] ma, md, rd; logic [3:0] mm;
        pData_bReqValid = 1'b1; pData_bWen = 1'b0; pData_bAddr = 32'h40; pData_bMask = 4'hF;
        @(negedge clock);
        n_cmp++;
        if (pData_bReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_accept: got %b expected 1", pData_bReqReady);
        end
        @(posedge clock); #1;
        pData_bReqValid = 1'b0;
        @(posedge clock); #1;
        resetN = 1'b0; pInst_bReqValid = 1'b1; pData_bReqValid = 1'b1;
        #1;
        n_cmp++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h expected 0", all_outs);
        end
        @(negedge clock);
        @(negedge clock);
        pInst_bReqValid = 1'b0; pData_bReqValid = 1'b0;
        resetN = 1'b1;
        ref_last_d = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            n_cmp++;
            if ({pInst_bRespValid, pData_bRespValid, pMem_bEn} !== 3'b000) begin
                n_fail++;
                $display("FAIL rstmid_quiet cyc %0d: got %b expected 000", k,
                         {pInst_bRespValid, pData_bRespValid, pMem_bEn});
            end
        end
        @(posedge clock); #1;
        stream(1'b1, 1'b1, 2, 1, 32'h0000_0008, 32'h0000_000C, 1'b0, "post_reset_tie");
        run_req(1'b0, 1'b0, 32'h0000_0040, '0, 4'hF, hw, ek, mw, ma, md, mm, rk, rd, st);
        n_cmp++;
        if (hw != 0 || rk != 2 + LAT || rd !== ref_mem[16]) begin
            n_fail++;
            $display("FAIL rstmid_idle: got wait %0d cyc %0d data %h expected 0 %0d %h", hw, rk, rd, 2 + LAT, ref_mem[16]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_last_d = 1'b1;
        resetN = 1'b0;
        pInst_bReqValid = 1'b0; pInst_bAddr = '0;
        pData_bReqValid = 1'b0; pData_bWen = 1'b0; pData_bAddr = '0;
        pData_bWrData = '0; pData_bMask = '0;
        test_reset();
        test_fetch();
        test_store();
        test_random();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
